tc_countdown_timer: RTL and testbench

- Down-counting timer, the counterpart of the up-counting load/count register in the component library.
- Loads a start value, decrements by STEP each clock while running, and signals terminal count.
- Optionally auto-reloads to give periodic ticks.
- Used as a delay/timeout and periodic-tick source beside the existing counter components.

---
 rtl/tc_countdown_pkg.sv | 23 ++
 rtl/tc_sat_decrement.sv | 24 ++
 rtl/tc_countdown_timer.sv | 83 ++++++++
 tb/tb_tc_countdown_timer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/tc_countdown_pkg.sv
// Shared types and elaboration helpers for the down-counting timer components.
package tc_countdown_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    HOLD = ST_HOLD,
    DONE = ST_DONE
  } state_e;

  // STEP must be non-zero and representable in BIT_WIDTH bits.
  function automatic bit step_legal(int unsigned bit_width, int unsigned step);
    if (step == 0) return 1'b0;
    if (bit_width >= 32) return 1'b1;
    return step <= ((32'd1 << bit_width) - 32'd1);
  endfunction

endpackage

// File: rtl/tc_sat_decrement.sv
// Saturating decrement by a constant STEP; flags when the next value hits terminal count.
module tc_sat_decrement
  import tc_countdown_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned STEP      = 1
) (
  input  logic [BIT_WIDTH-1:0] a,
  output logic [BIT_WIDTH-1:0] out_next,
  output logic                 terminal
);

  localparam logic [BIT_WIDTH-1:0] STEP_W = BIT_WIDTH'(STEP);

  if (!step_legal(BIT_WIDTH, STEP)) begin : g_bad_step
    $error("tc_sat_decrement: STEP out of range 1 .. 2^BIT_WIDTH-1");
  end

  always_comb begin
    terminal = (a <= STEP_W);
    out_next = terminal ? '0 : a - STEP_W;
  end

endmodule

// File: rtl/tc_countdown_timer.sv
// Loadable down-counting timer with pause/resume, terminal-count pulse and optional auto-reload.
module tc_countdown_timer
  import tc_countdown_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned STEP      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [BIT_WIDTH-1:0] in,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 reload_en,
  output logic [BIT_WIDTH-1:0] out,
  output logic                 running,
  output logic                 done,
  output logic                 expired
);

  state_e               state;
  logic [BIT_WIDTH-1:0] reload;
  logic [BIT_WIDTH-1:0] dec_next;
  logic                 dec_terminal;

  tc_sat_decrement #(
    .BIT_WIDTH(BIT_WIDTH),
    .STEP     (STEP)
  ) u_dec (
    .a       (out),
    .out_next(dec_next),
    .terminal(dec_terminal)
  );

  assign running = (state == RUN);
  assign expired = (state == DONE);

  // Priority per edge: load > stop (RUN only) > start > counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      out    <= '0;
      reload <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        out    <= in;
        reload <= in;
        state  <= (start && (in != '0)) ? RUN : IDLE;
      end else begin
        unique case (state)
          IDLE, HOLD: begin
            if (start && (out != '0)) state <= RUN;
          end
          DONE: begin
            if (start) begin
              out <= reload;
              if (reload != '0) state <= RUN;
            end
          end
          RUN: begin
            if (stop) begin
              state <= HOLD;
            end else if (dec_terminal) begin
              done <= 1'b1;
              if (reload_en && (reload != '0)) begin
                out <= reload;
              end else begin
                out   <= '0;
                state <= DONE;
              end
            end else begin
              out <= dec_next;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tc_countdown_timer.sv
// Directed + randomized bench for tc_countdown_timer at STEP=1 and STEP=4, checked against a behavioural model.
module tb_tc_countdown_timer;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         load;
  logic [W-1:0] din;
  logic         start;
  logic         stop;
  logic         reload_en;

  logic [W-1:0] out_w     [2];
  logic         running_w [2];
  logic         done_w    [2];
  logic         expired_w [2];

  int checks;
  int errors;
  int dn0;

  // Behavioural model: count value, reload value, and whether counting / expired.
  int m_out  [2];
  int m_rel  [2];
  bit m_run  [2];
  bit m_exp  [2];
  bit m_done [2];

  tc_countdown_timer #(.BIT_WIDTH(W), .STEP(1)) dut_s1 (
    .clk(clk), .rst(rst), .load(load), .in(din), .start(start), .stop(stop),
    .reload_en(reload_en), .out(out_w[0]), .running(running_w[0]),
    .done(done_w[0]), .expired(expired_w[0])
  );

  tc_countdown_timer #(.BIT_WIDTH(W), .STEP(4)) dut_s4 (
    .clk(clk), .rst(rst), .load(load), .in(din), .start(start), .stop(stop),
    .reload_en(reload_en), .out(out_w[1]), .running(running_w[1]),
    .done(done_w[1]), .expired(expired_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int step_of(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_out[k] = 0; m_rel[k] = 0; m_run[k] = 0; m_exp[k] = 0; m_done[k] = 0;
    end
  endfunction

  function automatic void model_step(int k);
    m_done[k] = 0;
    if (!rst) begin
      m_out[k] = 0; m_rel[k] = 0; m_run[k] = 0; m_exp[k] = 0;
    end else if (load) begin
      m_out[k] = int'(din);
      m_rel[k] = int'(din);
      m_run[k] = start && (din != 0);
      m_exp[k] = 0;
    end else if (m_run[k] && stop) begin
      m_run[k] = 0;
    end else if (m_run[k]) begin
      if (m_out[k] > step_of(k)) begin
        m_out[k] = m_out[k] - step_of(k);
      end else begin
        m_done[k] = 1;
        if (reload_en && m_rel[k] != 0) begin
          m_out[k] = m_rel[k];
        end else begin
          m_out[k] = 0; m_run[k] = 0; m_exp[k] = 1;
        end
      end
    end else if (start && m_exp[k]) begin
      m_out[k] = m_rel[k];
      if (m_rel[k] != 0) begin m_run[k] = 1; m_exp[k] = 0; end
    end else if (start && m_out[k] != 0) begin
      m_run[k] = 1;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic compare_model(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.out[s%0d]", tag, step_of(k)), 32'(out_w[k]), 32'(m_out[k]));
      chk($sformatf("%s.running[s%0d]", tag, step_of(k)), 32'(running_w[k]), 32'(m_run[k]));
      chk($sformatf("%s.done[s%0d]", tag, step_of(k)), 32'(done_w[k]), 32'(m_done[k]));
      chk($sformatf("%s.expired[s%0d]", tag, step_of(k)), 32'(expired_w[k]), 32'(m_exp[k]));
    end
  endtask

  task automatic tick(input string tag);
    for (int k = 0; k < 2; k++) model_step(k);
    @(posedge clk);
    #1;
    if (done_w[0] === 1'b1) dn0++;
    compare_model(tag);
  endtask

  task automatic idle_inputs();
    load = 0; start = 0; stop = 0;
  endtask

  initial begin
    checks = 0; errors = 0; dn0 = 0;
    rst = 0; load = 0; din = '0; start = 0; stop = 0; reload_en = 0;
    model_reset();
    #2;
    compare_model("reset");
    tick("reset_hold");
    tick("reset_hold2");
    rst = 1;

    // Basic count: load 5 with start.
    load = 1; din = 8'd5; start = 1;
    tick("basic_load");
    chk("basic_load_out", 32'(out_w[0]), 32'd5);
    idle_inputs();
    for (int i = 0; i < 4; i++) tick("basic_count");
    chk("basic_one", 32'(out_w[0]), 32'd1);
    tick("basic_term");
    chk("basic_zero", 32'(out_w[0]), 32'd0);
    chk("basic_done", 32'(done_w[0]), 32'd1);
    tick("basic_after");
    chk("basic_expired", 32'(expired_w[0]), 32'd1);
    chk("basic_not_running", 32'(running_w[0]), 32'd0);

    // Pause / resume.
    dn0 = 0;
    load = 1; din = 8'd10; start = 1;
    tick("pause_load");
    idle_inputs();
    for (int i = 0; i < 3; i++) tick("pause_count");
    stop = 1;
    tick("pause_stop");
    stop = 0;
    for (int i = 0; i < 3; i++) tick("pause_hold");
    chk("pause_hold_out", 32'(out_w[0]), 32'd7);
    chk("pause_hold_running", 32'(running_w[0]), 32'd0);
    start = 1;
    tick("pause_resume");
    start = 0;
    tick("pause_first_dec");
    chk("pause_resume_out", 32'(out_w[0]), 32'd6);
    for (int i = 0; i < 8; i++) tick("pause_tail");
    chk("pause_done_once", 32'(dn0), 32'd1);

    // Periodic reload.
    dn0 = 0;
    reload_en = 1;
    load = 1; din = 8'd3; start = 1;
    tick("per_load");
    idle_inputs();
    for (int i = 0; i < 9; i++) tick("per_run");
    chk("per_done_count", 32'(dn0), 32'd3);
    chk("per_out", 32'(out_w[0]), 32'd3);
    chk("per_not_expired", 32'(expired_w[0]), 32'd0);
    reload_en = 0;
    for (int i = 0; i < 3; i++) tick("per_halt");
    chk("per_halt_expired", 32'(expired_w[0]), 32'd1);

    // Priorities and corners.
    start = 1;
    tick("pri_rearm");
    chk("pri_rearm_out", 32'(out_w[0]), 32'd3);
    chk("pri_rearm_running", 32'(running_w[0]), 32'd1);
    load = 1; stop = 1; start = 1; din = 8'd8;
    tick("pri_load_wins");
    chk("pri_load_wins_out", 32'(out_w[0]), 32'd8);
    chk("pri_load_wins_running", 32'(running_w[0]), 32'd1);
    idle_inputs();
    load = 1; din = 8'd0;
    tick("pri_load_zero");
    load = 0; start = 1;
    tick("pri_start_zero");
    chk("pri_start_zero_running", 32'(running_w[0]), 32'd0);
    load = 1;
    tick("pri_load0_start");
    chk("pri_load0_start_running", 32'(running_w[0]), 32'd0);
    idle_inputs();

    // Asynchronous reset mid-run.
    load = 1; din = 8'd200; start = 1;
    tick("arst_load");
    idle_inputs();
    for (int i = 0; i < 50; i++) tick("arst_run");
    chk("arst_before", 32'(out_w[0]), 32'd150);
    #3;
    rst = 0;
    #1;
    model_reset();
    compare_model("arst_immediate");
    chk("arst_out_now", 32'(out_w[0]), 32'd0);
    tick("arst_held");
    rst = 1;
    dn0 = 0;
    for (int i = 0; i < 3; i++) tick("arst_release");
    chk("arst_no_done", 32'(dn0), 32'd0);

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      load      = ($urandom_range(0, 9) == 0);
      din       = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 5)) : W'($urandom);
      start     = ($urandom_range(0, 3) == 0);
      stop      = ($urandom_range(0, 11) == 0);
      reload_en = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 63) == 0) begin
        rst = 0;
        #2;
        model_reset();
        compare_model("rand_arst");
        rst = 1;
      end
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
